// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage core's pipeline stage registers:
// control-vector bit positions, per-stage payload widths and the skid
// buffer state encoding (used when PIPE_STAGE_SKID_EN is defined).
package pipe_pkg;

   // Bit positions inside the control vector carried between stages
   localparam int CTRL_MEM_WRITE  = 0;
   localparam int CTRL_MEM_READ   = 1;
   localparam int CTRL_REG_WRITE  = 2;
   localparam int CTRL_MEM_TO_REG = 3;
   localparam int CTRL_W_CORE     = 4;

   // Payload widths per stage boundary
   // ID/EX : 32 operand A + 32 operand B + 5 dest reg
   // EX/MEM: 32 ALU result + 32 store data + 5 dest reg
   // MEM/WB: 32 ALU result + 32 load data + 5 dest reg
   localparam int ID_EX_DATA_W  = 69;
   localparam int EX_MEM_DATA_W = 69;
   localparam int MEM_WB_DATA_W = 69;

   // Skid buffer occupancy
   typedef enum logic [1:0] {
      EMPTY = 2'd0,   // main register empty
      FULL  = 2'd1,   // main register holds a beat
      SKID  = 2'd2    // main and skid both hold a beat
   } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer and its occupancy FSM for pipe_stage_reg.
// Only instantiated when PIPE_STAGE_SKID_EN is defined. It makes in_ready a
// flop output, so there is no combinational path from out_ready to in_ready.
// It tells the stage's main register when to load and from where.
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 4,
   parameter int DATA_W = 69
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              emit,
   output logic              in_ready,
   output logic              main_load,
   output logic [CTRL_W-1:0] load_ctrl,
   output logic [DATA_W-1:0] load_data
);

   skid_state_t       state;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic              accept;

   assign accept = in_valid && in_ready;

   // Choose whether the main register loads this cycle, and from which source
   always_comb begin
      // NOTE: every output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
      main_load = 1'b0;
      load_ctrl = in_ctrl;
      load_data = in_data;
      case (state)
         EMPTY:   main_load = accept;
         FULL:    main_load = accept && emit;
         SKID: begin
            main_load = emit;
            load_ctrl = skid_ctrl;
            load_data = skid_data;
         end
         default: main_load = 1'b0;
      endcase
   end

   // Occupancy FSM with a registered in_ready; the skid entry captures a beat on FULL -> SKID
   always_ff @(posedge clk) begin
      // NOTE: skid_ctrl/skid_data are not reset; the state says whether they are meaningful.
      if (rst || flush) begin
         state    <= EMPTY;
         in_ready <= 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) state <= FULL;
            end
            FULL: begin
               if (accept && !emit) begin
                  state     <= SKID;
                  in_ready  <= 1'b0;
                  skid_ctrl <= in_ctrl;
                  skid_data <= in_data;
               end else if (emit && !accept) begin
                  state <= EMPTY;
               end
            end
            SKID: begin
               if (emit) begin
                  state    <= FULL;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state    <= EMPTY;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with a valid/ready handshake, flush and a
// saturating stall-cycle counter. It is used at ID/EX, EX/MEM and MEM/WB.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer, which makes
// in_ready a registered output. Otherwise in_ready = !out_valid || out_ready.
// out_ctrl is zero whenever out_valid is low, so a bubble never fires a
// downstream write enable.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 4,
   parameter int DATA_W = 69,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              emit;
   logic              main_load;
   logic [CTRL_W-1:0] load_ctrl;
   logic [DATA_W-1:0] load_data;

   assign emit = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
   pipe_skid_buf #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .emit      (emit),
      .in_ready  (in_ready),
      .main_load (main_load),
      .load_ctrl (load_ctrl),
      .load_data (load_data)
   );
`else
   assign in_ready  = !out_valid || out_ready;
   assign main_load = in_valid && in_ready;
   assign load_ctrl = in_ctrl;
   assign load_data = in_data;
`endif

   // Main register: reset, then flush, then load, then drain; ctrl is zeroed on every path to a bubble
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments in clocked blocks, so every flop samples pre-edge values.
      if (rst) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
         out_data  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
      end else if (main_load) begin
         out_valid <= 1'b1;
         out_ctrl  <= load_ctrl;
         out_data  <= load_data;
      end else if (emit) begin
         out_valid <= 1'b0;
         out_ctrl  <= '0;
      end
   end

   // Count cycles in which a held beat is back-pressured; stop at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
